cov_summary_unit: RTL and testbench
===================================

Name: cov_summary_unit

Overview:
- In-DUT producer of the 30-bit coverage summary; the testbench-side coverage monitor and collector consume it.
- Samples a vector of coverage points every cycle and keeps a sticky "ever hit" bitmap.
- A round-robin scanner popcounts newly hit points one chunk per cycle into a saturating sum.
- A snapshot handshake gives the collector a drained, stable sum at round end.

Parameters:
- NUM_POINTS, 256, number of coverage points; must be a multiple of CHUNK and < 2^SUM_W.
- CHUNK, 32, points popcounted per cycle; NUM_CHUNKS = NUM_POINTS/CHUNK, which must be ≥ 2.
- SUM_W, 30, width of the summary sum.

Ports:
- clock, input, 1: sole clock, rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- clear, input, 1: synchronous meta-clear between fuzz rounds; single-cycle or level.
- cov_points, input, NUM_POINTS: per-cycle coverage hit vector.
- snap_req, input, 1: collector requests a stable snapshot (level).
- snap_ack, input, 1: collector has consumed the snapshot.
- snap_valid, output, 1: snap_sum is stable and final.
- snap_sum, output, SUM_W: frozen sum presented during VALID.
- cov_sum, output, SUM_W: live running sum.
- busy, output, 1: pending bitmap non-empty or input stage non-zero.
- hit_pulse, output, 1: one-cycle pulse when a scanned chunk contributed ≥1 new point.

Behaviour:
- **Reset.** reset_n=0 at a clock edge clears cov_q, seen, pending, scan_idx, cov_sum, snap_sum, hit_pulse and snap_valid, and puts the FSM in IDLE. All outputs read 0 the cycle after reset. Reset overrides clear and the handshake.
- **Stage 1 (input register).** cov_q <= cov_points when state==IDLE, else cov_q <= 0.
- **Stage 2 (bitmap update).**
  - seen <= seen | cov_q.
  - pending <= (pending & ~mask(scan_idx)) | (cov_q & ~seen).
  - Invariant: pending ⊆ seen, so each point is counted exactly once. A new hit landing in the chunk being scanned that cycle stays pending for the next lap.
- **Scanner.**
  - Each cycle: n = popcount(pending[scan_idx*CHUNK +: CHUNK]).
  - cov_sum <= sat(cov_sum + n), saturating at 2^SUM_W-1.
  - hit_pulse <= (n != 0).
  - scan_idx wraps from NUM_CHUNKS-1 to 0.
- **Latency.** A point hit at cycle t is in cov_q at t+1 and in pending at t+2. It is added to cov_sum at most NUM_CHUNKS cycles later, visible the cycle after its chunk is scanned. Worst case is t+2+NUM_CHUNKS.
- **Snapshot FSM.**
  - IDLE: if snap_req go to DRAIN.
  - DRAIN: input sampling is gated. When pending==0 and cov_q==0, set snap_sum <= cov_sum and go to VALID. This takes at most NUM_CHUNKS+2 cycles.
  - VALID: snap_valid=1 and snap_sum is held. On snap_ack, go to IDLE and drop snap_valid in the same edge. snap_req deassert without ack is ignored; the FSM waits for ack.
  - snap_ack in IDLE or DRAIN is ignored.
  - Hits presented on cov_points while state≠IDLE are dropped by design, because the fuzz round is over.
- **clear (no reset).** Zeroes seen, pending, cov_q, cov_sum and scan_idx next cycle. FSM state and snap_sum are unchanged, so clear during VALID keeps the presented snapshot intact. clear during DRAIN completes immediately on the following cycle with snap_sum=0.
- **Simultaneous events.**
  - clear wins over a same-cycle scanner add.
  - A same-cycle cov_points hit alongside clear is discarded.
- **Saturation.** Unreachable under the parameter constraint but required; cov_sum never wraps.
- **busy** = (pending != 0) | (cov_q != 0), combinational.

Decomposition:
- **Package cov_summary_pkg:**
  - snapshot state enum {IDLE, DRAIN, VALID};
  - derived constants NUM_CHUNKS and IDX_W = $clog2(NUM_CHUNKS);
  - saturating-add function.
- **Sub-module cov_popcount:** purely combinational CHUNK-bit to $clog2(CHUNK+1)-bit adder tree, parameterised by CHUNK.
- **Top:** all registers and the FSM live in cov_summary_unit.

Test Plan:
- **Single hit.** Reset, then cov_points=1<<37 for one cycle → cov_sum becomes 1 within 2+8 cycles; hit_pulse pulses exactly once; busy returns to 0.
- **Repeat hit.** cov_points=0xFF for 20 consecutive cycles, then 0xFF again later → cov_sum=8 and never exceeds 8.
- **Race at the scan chunk.** Hit bit 5 on the exact cycle chunk 0 is being scanned with bit 3 already pending → bit 3 is counted in that scan, bit 5 on the next lap; final cov_sum=2.
- **Snapshot.** All 256 points hit in one cycle, snap_req asserted the next cycle → DRAIN ends, snap_valid=1 with snap_sum=256. Hits during DRAIN/VALID leave the sum unchanged. snap_ack → IDLE and snap_valid=0 next cycle.
- **clear.** clear during VALID with snap_sum=40 → cov_sum=0 next cycle; snap_sum stays 40 until ack. After ack, a fresh hit of the previously seen bit 3 yields cov_sum=1.
- **Reset mid-DRAIN.** reset_n=0 for one cycle with pending non-zero → snap_valid=0, cov_sum=0, busy=0, FSM in IDLE. A subsequent snap_req completes normally with snap_sum=0.

Source files
------------

// File: rtl/cov_summary_pkg.sv
// Shared types, constants and the saturating adder for the coverage summary unit.
package cov_summary_pkg;

   localparam int NUM_POINTS = 256;
   localparam int CHUNK      = 32;
   localparam int SUM_W      = 30;
   localparam int NUM_CHUNKS = NUM_POINTS / CHUNK;
   localparam int IDX_W      = $clog2(NUM_CHUNKS);
   localparam int CNT_W      = $clog2(CHUNK + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      VALID = 2'd2
   } snap_state_e;

   // Sum never wraps: an overflow into the extra carry bit pins the result at all-ones.
   function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
      logic [SUM_W:0] s;
      s = {1'b0, a} + {{(SUM_W + 1 - CNT_W){1'b0}}, b};
      if (s[SUM_W]) begin
         return {SUM_W{1'b1}};
      end else begin
         return s[SUM_W-1:0];
      end
   endfunction

endpackage

// File: rtl/cov_popcount.sv
// Combinational population count of one CHUNK-wide slice of the pending bitmap.
module cov_popcount #(
   parameter int CHUNK = 32
) (
   input  logic [CHUNK-1:0]               bits,
   output logic [$clog2(CHUNK + 1)-1:0]   count
);

   localparam int CNT_W = $clog2(CHUNK + 1);

   // Sum of all set bits in the slice.
   always_comb begin
      count = {CNT_W{1'b0}};
      for (int i = 0; i < CHUNK; i++) begin
         count = count + CNT_W'(bits[i]);
      end
   end

endmodule

// File: rtl/cov_summary_unit.sv
// Sticky coverage bitmap with a round-robin popcount scanner and a drain/snapshot
// handshake that hands the collector a stable summary at the end of a round.
module cov_summary_unit
   import cov_summary_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic [NUM_POINTS-1:0] cov_points,
   input  logic                  snap_req,
   input  logic                  snap_ack,
   output logic                  snap_valid,
   output logic [SUM_W-1:0]      snap_sum,
   output logic [SUM_W-1:0]      cov_sum,
   output logic                  busy,
   output logic                  hit_pulse
);

   snap_state_e           state_r;
   snap_state_e           next_state_s;
   logic [NUM_POINTS-1:0] cov_q_r;
   logic [NUM_POINTS-1:0] seen_r;
   logic [NUM_POINTS-1:0] pending_r;
   logic [NUM_POINTS-1:0] mask_s;
   logic [IDX_W-1:0]      scan_idx_r;
   logic [CHUNK-1:0]      chunk_s;
   logic [CNT_W-1:0]      chunk_cnt_s;
   logic [SUM_W-1:0]      cov_sum_r;
   logic [SUM_W-1:0]      snap_sum_r;
   logic                  snap_valid_r;
   logic                  hit_pulse_r;
   logic                  drained_s;

   // Select the chunk under the scanner and build its clear mask.
   always_comb begin
      mask_s = {NUM_POINTS{1'b0}};
      mask_s[scan_idx_r*CHUNK +: CHUNK] = {CHUNK{1'b1}};
      chunk_s = pending_r[scan_idx_r*CHUNK +: CHUNK];
   end

   cov_popcount #(.CHUNK(CHUNK)) u_popcount (
      .bits  (chunk_s),
      .count (chunk_cnt_s)
   );

   assign drained_s = (pending_r == {NUM_POINTS{1'b0}}) && (cov_q_r == {NUM_POINTS{1'b0}});

   // Snapshot FSM next state; a clear in DRAIN defers completion so the snapshot reads the zeroed sum.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (snap_req) next_state_s = DRAIN;
            else          next_state_s = IDLE;
         end
         DRAIN: begin
            if (drained_s && !clear) next_state_s = VALID;
            else                     next_state_s = DRAIN;
         end
         VALID: begin
            if (snap_ack) next_state_s = IDLE;
            else          next_state_s = VALID;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // FSM state, frozen snapshot and its valid flag; clear deliberately leaves these alone.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         snap_sum_r   <= {SUM_W{1'b0}};
         snap_valid_r <= 1'b0;
      end else begin
         state_r      <= next_state_s;
         snap_valid_r <= (next_state_s == VALID);
         if ((state_r == DRAIN) && (next_state_s == VALID)) begin
            snap_sum_r <= cov_sum_r;
         end else begin
            snap_sum_r <= snap_sum_r;
         end
      end
   end

   // Input stage, sticky bitmap, pending set and scanner; clear beats any same-cycle add.
   always_ff @(posedge clock) begin
      if (!reset_n || clear) begin
         cov_q_r     <= {NUM_POINTS{1'b0}};
         seen_r      <= {NUM_POINTS{1'b0}};
         pending_r   <= {NUM_POINTS{1'b0}};
         scan_idx_r  <= {IDX_W{1'b0}};
         cov_sum_r   <= {SUM_W{1'b0}};
         hit_pulse_r <= 1'b0;
      end else begin
         cov_q_r     <= (state_r == IDLE) ? cov_points : {NUM_POINTS{1'b0}};
         seen_r      <= seen_r | cov_q_r;
         pending_r   <= (pending_r & ~mask_s) | (cov_q_r & ~seen_r);
         cov_sum_r   <= sat_add(cov_sum_r, chunk_cnt_s);
         hit_pulse_r <= (chunk_cnt_s != {CNT_W{1'b0}});
         scan_idx_r  <= (scan_idx_r == IDX_W'(NUM_CHUNKS - 1)) ? {IDX_W{1'b0}}
                                                               : scan_idx_r + IDX_W'(1);
      end
   end

   assign busy       = (pending_r != {NUM_POINTS{1'b0}}) || (cov_q_r != {NUM_POINTS{1'b0}});
   assign snap_valid = snap_valid_r;
   assign snap_sum   = snap_sum_r;
   assign cov_sum    = cov_sum_r;
   assign hit_pulse  = hit_pulse_r;

endmodule

// File: tb/tb_cov_summary_unit.sv
// Self-checking bench for cov_summary_unit: table of single-cycle hit patterns with a
// scoreboard queue, plus hand-written race, snapshot, clear and reset sequences.
module tb_cov_summary_unit;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         clear = 1'b0;
   logic [255:0] cov_points = 256'd0;
   logic         snap_req = 1'b0;
   logic         snap_ack = 1'b0;
   logic         snap_valid;
   logic [29:0]  snap_sum;
   logic [29:0]  cov_sum;
   logic         busy;
   logic         hit_pulse;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      logic [255:0] pts;
      logic         do_clear;
      logic [29:0]  exp_sum;
      int           exp_pulses;
   } vec_t;

   vec_t vec[7];
   vec_t exp_q[$];

   cov_summary_unit dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear      (clear),
      .cov_points (cov_points),
      .snap_req   (snap_req),
      .snap_ack   (snap_ack),
      .snap_valid (snap_valid),
      .snap_sum   (snap_sum),
      .cov_sum    (cov_sum),
      .busy       (busy),
      .hit_pulse  (hit_pulse)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_clear;
      clear = 1'b1;
      tick;
      clear = 1'b0;
   endtask

   task automatic hit_once(input logic [255:0] p);
      cov_points = p;
      tick;
      cov_points = 256'd0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!snap_valid && cyc < 30) begin
         tick;
         cyc++;
      end
      check("valid_reached", 64'(snap_valid), 64'd1);
   endtask

   initial begin
      vec_t e;
      int   pulses;
      int   cyc;
      logic [29:0] max_sum;

      vec[0] = '{256'd1 << 37,         1'b1, 30'd1,   1};
      vec[1] = '{256'hFF,              1'b0, 30'd9,   1};
      vec[2] = '{256'hFF,              1'b0, 30'd9,   0};
      vec[3] = '{(256'd1 << 0) | (256'd1 << 32) | (256'd1 << 255), 1'b1, 30'd3, 3};
      vec[4] = '{{256{1'b1}},          1'b0, 30'd256, 8};
      vec[5] = '{256'd0,               1'b1, 30'd0,   0};
      vec[6] = '{{8{32'h5555_5555}},   1'b1, 30'd128, 8};

      // reset state
      tick;
      tick;
      check("rst_snap_valid", 64'(snap_valid), 64'd0);
      check("rst_snap_sum",   64'(snap_sum),   64'd0);
      check("rst_cov_sum",    64'(cov_sum),    64'd0);
      check("rst_busy",       64'(busy),       64'd0);
      check("rst_hit_pulse",  64'(hit_pulse),  64'd0);
      reset_n = 1'b1;
      tick;

      // table-driven single-cycle patterns
      for (int v = 0; v < 7; v++) begin
         if (vec[v].do_clear) do_clear;
         exp_q.push_back(vec[v]);
         hit_once(vec[v].pts);
         pulses = 0;
         for (int c = 0; c < 12; c++) begin
            tick;
            if (hit_pulse) pulses++;
         end
         e = exp_q.pop_front();
         check($sformatf("vec%0d_sum", v),    64'(cov_sum), 64'(e.exp_sum));
         check($sformatf("vec%0d_pulses", v), 64'(pulses),  64'(e.exp_pulses));
         check($sformatf("vec%0d_busy", v),   64'(busy),    64'd0);
      end

      // repeat hit held for 20 cycles, then again later
      do_clear;
      max_sum = 30'd0;
      cov_points = 256'hFF;
      for (int c = 0; c < 20; c++) begin
         tick;
         if (cov_sum > max_sum) max_sum = cov_sum;
      end
      cov_points = 256'd0;
      for (int c = 0; c < 12; c++) begin
         tick;
         if (cov_sum > max_sum) max_sum = cov_sum;
      end
      hit_once(256'hFF);
      for (int c = 0; c < 12; c++) begin
         tick;
         if (cov_sum > max_sum) max_sum = cov_sum;
      end
      check("repeat_sum", 64'(cov_sum), 64'd8);
      check("repeat_max", 64'(max_sum), 64'd8);

      // new hit lands on chunk 0 in the very cycle chunk 0 is scanned
      do_clear;
      tick;
      hit_once(256'd1 << 3);
      repeat (5) tick;
      hit_once(256'd1 << 5);
      tick;
      check("race_first_lap", 64'(cov_sum), 64'd1);
      check("race_busy",      64'(busy),    64'd1);
      repeat (7) tick;
      check("race_pre_lap2",  64'(cov_sum), 64'd1);
      tick;
      check("race_final",     64'(cov_sum), 64'd2);

      // full snapshot
      do_clear;
      hit_once({256{1'b1}});
      snap_req = 1'b1;
      tick;
      snap_req = 1'b0;
      wait_valid(cyc);
      check("drain_len_ok", 64'(cyc <= 10), 64'd1);
      check("snap256_sum",  64'(snap_sum),  64'd256);
      check("snap256_live", 64'(cov_sum),   64'd256);
      check("snap256_busy", 64'(busy),      64'd0);
      snap_ack = 1'b1;
      tick;
      snap_ack = 1'b0;
      check("snap256_ack",  64'(snap_valid), 64'd0);

      // hits during DRAIN/VALID are dropped; req drop without ack is ignored
      do_clear;
      hit_once(256'hFFFF);
      snap_req = 1'b1;
      tick;
      snap_req = 1'b0;
      cov_points = 256'd1 << 200;
      wait_valid(cyc);
      repeat (3) tick;
      check("gate_hold_valid", 64'(snap_valid), 64'd1);
      check("gate_snap_sum",   64'(snap_sum),   64'd16);
      snap_ack = 1'b1;
      cov_points = 256'd0;
      tick;
      snap_ack = 1'b0;
      repeat (12) tick;
      check("gate_cov_sum",    64'(cov_sum),    64'd16);

      // clear during VALID keeps the snapshot
      do_clear;
      hit_once(256'hFF_FFFF_FFFF);
      repeat (12) tick;
      snap_req = 1'b1;
      tick;
      snap_req = 1'b0;
      wait_valid(cyc);
      check("clr_snap40",   64'(snap_sum),   64'd40);
      do_clear;
      check("clr_cov_sum",  64'(cov_sum),    64'd0);
      check("clr_snap_kept",64'(snap_sum),   64'd40);
      check("clr_valid",    64'(snap_valid), 64'd1);
      repeat (3) tick;
      check("clr_snap_hold",64'(snap_sum),   64'd40);
      snap_ack = 1'b1;
      tick;
      snap_ack = 1'b0;
      check("clr_ack",      64'(snap_valid), 64'd0);
      hit_once(256'd1 << 3);
      repeat (12) tick;
      check("clr_rehit",    64'(cov_sum),    64'd1);

      // clear during DRAIN completes next cycle with a zero snapshot
      do_clear;
      hit_once({256{1'b1}});
      snap_req = 1'b1;
      tick;
      snap_req = 1'b0;
      do_clear;
      tick;
      check("drainclr_valid", 64'(snap_valid), 64'd1);
      check("drainclr_sum",   64'(snap_sum),   64'd0);
      snap_ack = 1'b1;
      tick;
      snap_ack = 1'b0;

      // reset in the middle of DRAIN
      do_clear;
      hit_once({256{1'b1}});
      snap_req = 1'b1;
      tick;
      snap_req = 1'b0;
      tick;
      tick;
      reset_n = 1'b0;
      tick;
      reset_n = 1'b1;
      check("rstd_valid", 64'(snap_valid), 64'd0);
      check("rstd_sum",   64'(cov_sum),    64'd0);
      check("rstd_busy",  64'(busy),       64'd0);
      check("rstd_pulse", 64'(hit_pulse),  64'd0);
      snap_req = 1'b1;
      tick;
      snap_req = 1'b0;
      wait_valid(cyc);
      check("rstd_snap",  64'(snap_sum),   64'd0);
      snap_ack = 1'b1;
      tick;
      snap_ack = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
